msg_decoder: RTL

MSG_DECODER -- requirements
Module: msg_decoder

---
 rtl/lwe_pkg.sv | 26 ++
 rtl/msg_decoder_fifo.sv | 44 ++++
 rtl/msg_decoder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/lwe_pkg.sv
// Shared LWE decode constants, FSM state type and lane helper functions.
package lwe_pkg;

  localparam int LANE_W = 6;
  localparam int LANES  = 4;
  localparam int Q      = 64;
  localparam int Q_QTR  = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    ERR   = 2'd2
  } dec_state_t;

  // A lane decodes to 1 when its difference lies in the middle half of the ring.
  function automatic logic lane_bit(input logic [LANE_W-1:0] d);
    return (d >= LANE_W'(Q_QTR)) && (d < LANE_W'(Q - Q_QTR));
  endfunction

  // Weak: within two steps of either decision threshold.
  function automatic logic lane_weak(input logic [LANE_W-1:0] d);
    return ((d >= LANE_W'(Q_QTR - 2)) && (d <= LANE_W'(Q_QTR + 1))) ||
           ((d >= LANE_W'(Q - Q_QTR - 2)) && (d <= LANE_W'(Q - Q_QTR + 1)));
  endfunction

endpackage

// File: rtl/msg_decoder_fifo.sv
// Two-entry output FIFO; pop_data reads 0 while empty.
module msg_decoder_fifo #(
  parameter int W = 9
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         valid,
  output logic [W-1:0] pop_data
);

  logic [W-1:0] mem_reg [2];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  logic [1:0]   count_reg;
  logic         push_ok;
  logic         pop_ok;

  assign full     = (count_reg == 2'd2);
  assign valid    = (count_reg != 2'd0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && valid;
  assign pop_data = valid ? mem_reg[rd_ptr_reg] : '0;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < 2; i++) mem_reg[i] <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop_ok) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + 2'(push_ok) - 2'(pop_ok);
    end
  end

endmodule

// File: rtl/msg_decoder.sv
// Pairs ciphertext and inner-product words, decodes 4 bits per word, emits bytes.
// Optional out_weak margin flag enabled by defining MSG_DECODER_MARGIN_EN.
module msg_decoder
  import lwe_pkg::*;
#(
  parameter int DEPTH = 784
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        ct_valid,
  input  logic [23:0] ct_in,
  input  logic [9:0]  ct_idx,
  output logic        ct_ready,
  input  logic        ip_valid,
  input  logic [23:0] ip_in,
  input  logic [9:0]  ip_idx,
  output logic        ip_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
`ifdef MSG_DECODER_MARGIN_EN
  output logic        out_weak,
`endif
  output logic        err
);

  localparam logic [9:0] LAST_IDX  = 10'(DEPTH - 1);
  localparam bit         DEPTH_ODD = (DEPTH % 2) == 1;
`ifdef MSG_DECODER_MARGIN_EN
  localparam int FW = 10;
`else
  localparam int FW = 9;
`endif

  dec_state_t       state_reg, state_next;
  logic [9:0]       exp_idx_reg, exp_idx_next;
  logic [3:0]       nib_reg, nib_next;
  logic [LANES-1:0] bits;
  logic             pair_ok, fire, drop, at_last;
  logic             push, push_last;
  logic [7:0]       push_byte;
  logic [FW-1:0]    push_data, pop_data;
  logic             fifo_full, fifo_valid;
`ifdef MSG_DECODER_MARGIN_EN
  logic [LANES-1:0] weak_lanes;
  logic             weak_reg, weak_next, push_weak;
`endif

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [LANE_W-1:0] d;
    assign d        = ct_in[gi*LANE_W +: LANE_W] - ip_in[gi*LANE_W +: LANE_W];
    assign bits[gi] = lane_bit(d);
`ifdef MSG_DECODER_MARGIN_EN
    assign weak_lanes[gi] = lane_weak(d);
`endif
  end

  // Reset is folded in so the readies stay low while rst_n_in is held.
  assign pair_ok  = rst_n_in && ct_valid && ip_valid && (state_reg == RUN);
  assign fire     = pair_ok && (ip_idx == ct_idx) && !fifo_full;
  assign drop     = pair_ok && (ip_idx < ct_idx);
  assign ct_ready = fire;
  assign ip_ready = fire || drop;
  assign at_last  = (exp_idx_reg == LAST_IDX);

  always_comb begin
    state_next   = state_reg;
    exp_idx_next = exp_idx_reg;
    nib_next     = nib_reg;
    push         = 1'b0;
    push_byte    = 8'h00;
    push_last    = 1'b0;
`ifdef MSG_DECODER_MARGIN_EN
    weak_next    = weak_reg;
    push_weak    = 1'b0;
`endif
    case (state_reg)
      RUN: begin
        if (fire) begin
          if (ct_idx != exp_idx_reg) begin
            state_next = ERR;
          end else begin
            exp_idx_next = at_last ? 10'd0 : 10'(exp_idx_reg + 10'd1);
            if (!exp_idx_reg[0]) begin
              nib_next = bits;
`ifdef MSG_DECODER_MARGIN_EN
              weak_next = |weak_lanes;
`endif
              if (DEPTH_ODD && at_last) state_next = FLUSH;
            end else begin
              push      = 1'b1;
              push_byte = {bits, nib_reg};
              push_last = at_last;
`ifdef MSG_DECODER_MARGIN_EN
              push_weak = weak_reg || (|weak_lanes);
`endif
            end
          end
        end
      end
      FLUSH: begin
        // Odd-length frame: the final even word goes out alone.
        if (!fifo_full) begin
          push       = 1'b1;
          push_byte  = {4'h0, nib_reg};
          push_last  = 1'b1;
          state_next = RUN;
`ifdef MSG_DECODER_MARGIN_EN
          push_weak  = weak_reg;
`endif
        end
      end
      ERR:     state_next = ERR;
      default: state_next = RUN;
    endcase
  end

`ifdef MSG_DECODER_MARGIN_EN
  assign push_data = {push_weak, push_last, push_byte};
  assign out_weak  = pop_data[9];
`else
  assign push_data = {push_last, push_byte};
`endif
  assign out_data  = pop_data[7:0];
  assign out_last  = pop_data[8];
  assign out_valid = fifo_valid;
  assign err       = (state_reg == ERR);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg   <= RUN;
      exp_idx_reg <= 10'd0;
      nib_reg     <= 4'h0;
`ifdef MSG_DECODER_MARGIN_EN
      weak_reg    <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      exp_idx_reg <= exp_idx_next;
      nib_reg     <= nib_next;
`ifdef MSG_DECODER_MARGIN_EN
      weak_reg    <= weak_next;
`endif
    end
  end

  msg_decoder_fifo #(.W(FW)) u_fifo (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready),
    .full      (fifo_full),
    .valid     (fifo_valid),
    .pop_data  (pop_data)
  );

endmodule
